// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Width needed for a counter that must hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fifo_rr_arb_if.sv
// Producer/FIFO-write bundle for fifo_rr_arb; slave is the arbiter, master the producers + FIFO.
interface fifo_rr_arb_if
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = DEFAULT_WIDTH
);

  // Handshake: a beat of producer i moves on a rising edge where req_valid[i] and
  // req_ready[i] are both high; req_valid/req_data must stay stable until then.
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   fifo_full;
  logic                   fifo_we;
  logic [WIDTH-1:0]       fifo_in;
  logic [N_REQ-1:0]       grant;
  arb_state_t             dbg_state;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_we, fifo_in, grant, dbg_state
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_we, fifo_in, grant, dbg_state
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin search: first set bit of req at or above start, wrapping around.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] pick
);

  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the nearest hit is the last one written.
  always_comb begin
    found = |req;
    pick  = start;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IW'((int'(start) + i) % N);
      if (req[idx]) pick = idx;
    end
  end

endmodule

// File: rtl/fifo_rr_arb.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers with bounded bursts.
// Optional per-requester beat counters are enabled with FIFO_RR_ARB_STATS_EN.
module fifo_rr_arb
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  fifo_rr_arb_if.slave              bus
`ifdef FIFO_RR_ARB_STATS_EN
  ,
  input  logic [$clog2(N_REQ)-1:0]  stat_sel,
  input  logic                      stat_clr,
  output logic [15:0]               stat_cnt
`endif
);

  localparam int            IW        = $clog2(N_REQ);
  localparam int            BW        = cnt_width(MAX_BURST);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_REQ - 1);

  arb_state_t       state;
  logic [N_REQ-1:0] grant_q;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    pick;
  logic [BW-1:0]    beat_cnt;
  logic             found;
  logic             owner_valid;
  logic             xfer;

  rr_pick #(.N(N_REQ)) u_pick (
    .req   (bus.req_valid),
    .start (rr_ptr),
    .found (found),
    .pick  (pick)
  );

  assign owner_valid   = bus.req_valid[owner];
  assign xfer          = (state == GRANT) && owner_valid && !bus.fifo_full;
  assign bus.req_ready = grant_q & {N_REQ{xfer}};
  assign bus.fifo_we   = xfer;
  assign bus.fifo_in   = (state == GRANT) ? bus.req_data[owner*WIDTH +: WIDTH] : '0;
  assign bus.grant     = grant_q;
  assign bus.dbg_state = state;

  // A full FIFO freezes the burst in place; only an idle owner or a spent burst rotates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      grant_q  <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state    <= GRANT;
            grant_q  <= N_REQ'(1) << pick;
            owner    <= pick;
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (!owner_valid || (xfer && beat_cnt == LAST_BEAT)) begin
            state    <= IDLE;
            grant_q  <= '0;
            beat_cnt <= '0;
            rr_ptr   <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
          end else if (xfer) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_RR_ARB_STATS_EN
  logic [15:0] stat_q [N_REQ];

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) stat_q[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < N_REQ; i++) stat_q[i] <= '0;
    end else if (xfer && stat_q[owner] != 16'hFFFF) begin
      stat_q[owner] <= stat_q[owner] + 16'd1;
    end
  end

  assign stat_cnt = stat_q[stat_sel];
`endif

endmodule

// File: tb/tb_fifo_rr_arb.sv
// Randomized + directed bench for fifo_rr_arb against a queue-based arbitration model.
module tb_fifo_rr_arb;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int QD = 512;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_rr_arb_if #(.N_REQ(N), .WIDTH(W)) bus ();

`ifdef FIFO_RR_ARB_STATS_EN
  logic [1:0]  stat_sel;
  logic        stat_clr;
  logic [15:0] stat_cnt;
`endif

  fifo_rr_arb #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef FIFO_RR_ARB_STATS_EN
    ,
    .stat_sel (stat_sel),
    .stat_clr (stat_clr),
    .stat_cnt (stat_cnt)
`endif
  );

  // ---------------- producers, model, scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] src_mem [N][QD];
  int           src_hd  [N];
  int           src_tl  [N];
  logic [W-1:0] exp_q [$];

  logic [N-1:0] drv_v;
  logic [W-1:0] drv_d [N];
  logic         full_v;

  int m_owner;
  int m_ptr;
  int m_beats;

  logic [N-1:0] obs_grant, obs_ready;
  logic         obs_we;
  logic [W-1:0] obs_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int src_cnt(input int i);
    return src_tl[i] - src_hd[i];
  endfunction

  task automatic src_push(input int i, input logic [W-1:0] v);
    if (src_cnt(i) == 0) begin
      src_hd[i] = 0;
      src_tl[i] = 0;
    end
    src_mem[i][src_tl[i]] = v;
    src_tl[i]++;
  endtask

  function automatic int total_pending();
    int t = 0;
    for (int i = 0; i < N; i++) t += src_cnt(i);
    return t;
  endfunction

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      src_hd[i] = 0;
      src_tl[i] = 0;
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_beats = 0;
    exp_q.delete();
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      drv_v[i] = (src_cnt(i) > 0);
      drv_d[i] = drv_v[i] ? src_mem[i][src_hd[i]] : '0;
      bus.req_data[i*W +: W] = drv_d[i];
    end
    bus.req_valid = drv_v;
    bus.fifo_full = full_v;
  endtask

  // One clock: drive at negedge, compare mid-low-phase, advance producers and model at posedge.
  task automatic step();
    logic [N-1:0] e_g, e_r;
    logic         e_we;
    logic [W-1:0] e_in;
    bit           hit;
    int           c;
    @(negedge clk);
    drive_inputs();
    #1;
    e_g  = '0;
    e_r  = '0;
    e_we = 1'b0;
    e_in = '0;
    if (m_owner >= 0) begin
      e_g[m_owner] = 1'b1;
      e_in = drv_d[m_owner];
      if (drv_v[m_owner] && !full_v) begin
        e_we = 1'b1;
        e_r[m_owner] = 1'b1;
        exp_q.push_back(drv_d[m_owner]);
      end
    end
    obs_grant = bus.grant;
    obs_ready = bus.req_ready;
    obs_we    = bus.fifo_we;
    obs_in    = bus.fifo_in;
    chk("grant", obs_grant, e_g);
    chk("req_ready", obs_ready, e_r);
    chk("fifo_we", obs_we, e_we);
    chk("fifo_in", obs_in, e_in);
    chk("dbg_state", bus.dbg_state, (m_owner >= 0) ? GRANT : IDLE);
    if (obs_we) begin
      chk("write_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("written_data", obs_in, exp_q.pop_front());
    end
    if (e_we || obs_we) chk("scoreboard_level", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    for (int i = 0; i < N; i++)
      if (obs_ready[i] && src_cnt(i) > 0) src_hd[i]++;
    if (m_owner < 0) begin
      hit = 1'b0;
      for (int j = 0; j < N; j++) begin
        c = (m_ptr + j) % N;
        if (!hit && drv_v[c]) begin
          hit     = 1'b1;
          m_owner = c;
          m_beats = 0;
        end
      end
    end else if (!drv_v[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else if (e_we) begin
      m_beats++;
      if (m_beats == MB) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  task automatic drain(input int max_cycles);
    int c = 0;
    full_v = 1'b0;
    while (total_pending() > 0 && c < max_cycles) begin
      step();
      c++;
    end
    chk("drain_pending", total_pending(), 0);
    repeat (2) step();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    full_v = 1'b0;
    clear_sources();
    drive_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0;
    full_v = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
`ifdef FIFO_RR_ARB_STATS_EN
    stat_sel = 2'd2;
    stat_clr = 1'b0;
`endif
    clear_sources();
    model_reset();

    // Reset state and quiet idle after release
    #29;
    chk("rst_grant", bus.grant, 0);
    chk("rst_we", bus.fifo_we, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_state", bus.dbg_state, IDLE);
    #1 rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("idle_grant", obs_grant, 4'b0000);
      chk("idle_we", obs_we, 0);
    end

    // Single requester 0 writes 5,6,7 then drops valid
    src_push(0, 8'd5); src_push(0, 8'd6); src_push(0, 8'd7);
    step();
    chk("t2_arb_grant", obs_grant, 4'b0000);
    chk("t2_arb_we", obs_we, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2_grant", obs_grant, 4'b0001);
      chk("t2_we", obs_we, 1);
      chk("t2_data", obs_in, 5 + k);
    end
    step();
    chk("t2_drop_grant", obs_grant, 4'b0001);
    chk("t2_drop_we", obs_we, 0);
    step();
    chk("t2_rotated_grant", obs_grant, 4'b0000);

    // Two always-valid requesters alternate full bursts
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      src_push(0, 8'h10 + 8'(k));
      src_push(1, 8'h20 + 8'(k));
    end
    step();
    chk("t3_arb0", obs_grant, 4'b0000);
    for (int k = 0; k < MB; k++) begin
      step();
      chk("t3_grant0", obs_grant, 4'b0001);
      chk("t3_data0", obs_in, 8'h10 + k);
    end
    step();
    chk("t3_arb1", obs_grant, 4'b0000);
    for (int k = 0; k < MB; k++) begin
      step();
      chk("t3_grant1", obs_grant, 4'b0010);
      chk("t3_data1", obs_in, 8'h20 + k);
    end
    step();
    chk("t3_arb2", obs_grant, 4'b0000);
    drain(500);

    // FIFO full for 3 cycles after beat 2
    apply_reset();
    for (int k = 0; k < 6; k++) src_push(0, 8'h30 + 8'(k));
    step();
    step(); chk("t4_b1", obs_in, 8'h30);
    step(); chk("t4_b2", obs_in, 8'h31);
    full_v = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_full_we", obs_we, 0);
      chk("t4_full_ready", obs_ready, 4'b0000);
      chk("t4_full_grant", obs_grant, 4'b0001);
    end
    full_v = 1'b0;
    step(); chk("t4_b3", obs_in, 8'h32); chk("t4_b3_we", obs_we, 1);
    step(); chk("t4_b4", obs_in, 8'h33); chk("t4_b4_we", obs_we, 1);
    step(); chk("t4_rotate", obs_grant, 4'b0000);
    drain(500);

    // Asynchronous reset in the middle of a burst
    apply_reset();
    for (int k = 0; k < 6; k++) src_push(1, 8'h40 + 8'(k));
    step();
    step(); chk("t5_b1", obs_in, 8'h40);
    step(); chk("t5_b2", obs_in, 8'h41);
    @(negedge clk);
    drive_inputs();
    #1 chk("t5_pre_we", bus.fifo_we, 1);
    rst = 1'b0;
    #1;
    chk("t5_async_grant", bus.grant, 0);
    chk("t5_async_we", bus.fifo_we, 0);
    chk("t5_async_ready", bus.req_ready, 0);
    model_reset();
    clear_sources();
    drive_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    src_push(0, 8'h50); src_push(1, 8'h60); src_push(2, 8'h70);
    step(); chk("t5_rearb", obs_grant, 4'b0000);
    step(); chk("t5_restart_grant", obs_grant, 4'b0001); chk("t5_restart_data", obs_in, 8'h50);
    drain(500);

    // Randomized traffic with random back-pressure
    for (int cyc = 0; cyc < 3000; cyc++) begin
      full_v = ($urandom_range(0, 99) < 20);
      for (int i = 0; i < N; i++) begin
        if (src_cnt(i) == 0 && $urandom_range(0, 99) < 30) begin
          int nb = $urandom_range(1, 6);
          for (int b = 0; b < nb; b++) src_push(i, W'($urandom_range(0, 255)));
        end
      end
      step();
    end
    drain(1000);

`ifdef FIFO_RR_ARB_STATS_EN
    apply_reset();
    for (int k = 0; k < 300; k++) src_push(2, W'(k));
    drain(2000);
    stat_sel = 2'd2;
    #1 chk("stat_cnt_300", stat_cnt, 300);
    stat_sel = 2'd0;
    #1 chk("stat_cnt_other", stat_cnt, 0);
    stat_sel = 2'd2;
    @(negedge clk) stat_clr = 1'b1;
    @(negedge clk) stat_clr = 1'b0;
    #1 chk("stat_cnt_clr", stat_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached with %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_rr_arb.md
Name: fifo_rr_arb

Overview:
- Round-robin write-side arbiter sharing one 8-bit `fifo` instance between N_REQ producers.
- Each producer offers data with a valid/ready handshake.
- The arbiter grants one producer at a time for a bounded burst and drives the FIFO's `we`/`in`, honouring `full`.
- Sits directly in front of the `fifo` write port; the read side is untouched.

Parameters:
- N_REQ, 4: number of requesting producers (2..8).
- WIDTH, 8: data width; matches FIFO data width.
- MAX_BURST, 4: maximum beats written per grant before forced rotation (1..15).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset (state cleared while 0, independent of clk).
- req_valid  input  N_REQ  producer i has a beat on req_data.
- req_data  input  N_REQ*WIDTH  packed producer data; slice i = bits [i*WIDTH +: WIDTH].
- req_ready  output  N_REQ  beat of producer i accepted this cycle.
- fifo_full  input  1  FIFO `full` flag.
- fifo_we  output  1  FIFO write enable.
- fifo_in  output  WIDTH  FIFO write data.
- grant  output  N_REQ  one-hot current owner, or 0 in IDLE.

Behaviour:
- Reset (rst=0): state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, req_ready=0, fifo_we=0.
  - fifo_in is a don't-care; it is driven 0 while grant=0.
  - Reset mid-burst abandons the burst. Only beats already accepted reach the FIFO; no partial write occurs.
- States: IDLE, GRANT.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from rr_ptr upward with wrap.
  - Register grant = one-hot(pick) and beat_cnt=0, then go to GRANT.
  - Arbitration costs exactly 1 cycle; no writes happen in IDLE.
- GRANT (owner k):
  - Transfer condition: xfer = req_valid[k] & ~fifo_full.
  - req_ready[k] = xfer and fifo_we = xfer, both combinational. fifo_in = req_data slice k.
  - All other req_ready bits are 0.
  - On xfer, beat_cnt increments.
- Leave GRANT (to IDLE, rr_ptr = (k+1) mod N_REQ, grant=0) when either:
  - xfer occurs and beat_cnt reaches MAX_BURST-1, or
  - req_valid[k]=0 (owner idle).
- fifo_full with owner valid: hold grant, no write, beat_cnt frozen. No timeout.
- Owner drops valid while full: rotates as above.
- Producers must hold req_valid and req_data stable until req_ready. The arbiter does not check this.
- Fairness:
  - A continuously requesting producer waits at most (N_REQ-1)*(MAX_BURST+1) write-capable cycles.
  - A single requester re-wins after 1 IDLE cycle per burst.
- beat_cnt width is clog2(MAX_BURST+1); it never wraps.

Optional Feature:
- Macro FIFO_RR_ARB_STATS_EN.
- When defined, adds:
  - input stat_sel [clog2(N_REQ)-1:0]
  - input stat_clr (synchronous)
  - output stat_cnt [15:0]
- Implements per-requester 16-bit saturating counters of accepted beats, read combinationally via stat_sel.
- Counters reset to 0 on rst or stat_clr; stat_clr takes priority over same-cycle increment.
- When undefined, these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fifo_arb_pkg: state enum {IDLE, GRANT}, default WIDTH=8, and a clog2-based counter width function.
- One combinational sub-module rr_pick: inputs req vector and start pointer; outputs found flag and pick index.
- The FSM, counters and muxing stay in fifo_rr_arb.

Test Plan:
- rst=0 for 30ns, then release with all req_valid=0 -> grant=0, fifo_we=0 for 5 cycles.
- Only req0 valid with data 5,6,7 then drops -> IDLE 1 cycle, then fifo_we on 3 consecutive cycles writing 5,6,7. Rotates on valid drop.
- req0 and req1 always valid, MAX_BURST=4 -> writes alternate 4 from req0, IDLE cycle, 4 from req1, IDLE; grant sequence 0001,0000,0010,0000.
- fifo_full asserted for 3 cycles mid-burst after beat 2 -> fifo_we=0 and req_ready=0 for those cycles, grant held. Burst resumes at beat 3; total 4 beats.
- rst pulled low during GRANT after 2 beats -> grant and fifo_we=0 immediately (async). After release, arbitration restarts from requester 0.
- With FIFO_RR_ARB_STATS_EN: 300 beats from req2, then stat_sel=2 -> stat_cnt=300. After stat_clr -> stat_cnt=0.
